led_blinker_multi: RTL and testbench

Multi-channel LED blinker that supersedes the single-output blinker. A single synchronous prescaler chain (no derived clocks) produces four phase-aligned square-wave rates. NUM_CH independent channels each pick a rate and a mode (off / on / blink). Rate changes are glitch-free and take effect only at a period boundary of the currently active rate. The block sits between the board switch/register inputs and the LED pins, clocked by the 25 kHz system clock.

---
 rtl/led_blinker_multi_if.sv | 23 ++
 rtl/led_blinker_multi.sv | 86 ++++++++
 tb/tb_led_blinker_multi.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/led_blinker_multi_if.sv
// Signal bundle between the board switch/register side and the LED blinker.
// No handshake: inputs are level signals sampled every clock, outputs are registered or decoded from counters.
interface led_blinker_multi_if #(
    parameter int NUM_CH = 4
);
    logic                  enable;
    logic [2*NUM_CH-1:0]   sel;
    logic [2*NUM_CH-1:0]   mode;
    logic [NUM_CH-1:0]     led_drive;
    logic [3:0]            tick;
    // Active rate per channel, exported for observation only.
    logic [2*NUM_CH-1:0]   act_sel;

    modport master (
        output enable, sel, mode,
        input  led_drive, tick, act_sel
    );

    modport slave (
        input  enable, sel, mode,
        output led_drive, tick, act_sel
    );
endinterface

// File: rtl/led_blinker_multi.sv
// Multi-channel LED blinker: one synchronous prescaler chain gives four phase-aligned rates;
// each channel picks a rate (switched only at the active rate's period boundary) and a mode.
module led_blinker_multi #(
    parameter int NUM_CH = 4,
    parameter int DIV0   = 250,
    parameter int DIV1   = 2,
    parameter int DIV2   = 5,
    parameter int DIV3   = 10
) (
    input  logic              clock,
    input  logic              reset_n,
    led_blinker_multi_if.slave bus
);
    localparam int W0 = (DIV0 > 1) ? $clog2(DIV0) : 1;
    localparam int W1 = (DIV1 > 1) ? $clog2(DIV1) : 1;
    localparam int W2 = (DIV2 > 1) ? $clog2(DIV2) : 1;
    localparam int W3 = (DIV3 > 1) ? $clog2(DIV3) : 1;

    logic [W0-1:0] cnt0;
    logic [W1-1:0] cnt1;
    logic [W2-1:0] cnt2;
    logic [W3-1:0] cnt3;

    logic [3:0] tick_w;
    logic [3:0] sq;

    logic [NUM_CH-1:0][1:0] act_sel;
    logic [NUM_CH-1:0]      led_next;
    logic [NUM_CH-1:0]      led_q;

    // Each stage ticks only on the last cycle of every lower stage, so all rates share boundaries.
    always_comb begin
        tick_w[0] = (cnt0 == W0'(DIV0 - 1));
        tick_w[1] = tick_w[0] && (cnt1 == W1'(DIV1 - 1));
        tick_w[2] = tick_w[1] && (cnt2 == W2'(DIV2 - 1));
        tick_w[3] = tick_w[2] && (cnt3 == W3'(DIV3 - 1));
        sq[0]     = (cnt0 >= W0'(DIV0 / 2));
        sq[1]     = (cnt1 >= W1'(DIV1 / 2));
        sq[2]     = (cnt2 >= W2'(DIV2 / 2));
        sq[3]     = (cnt3 >= W3'(DIV3 / 2));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
            cnt2 <= '0;
            cnt3 <= '0;
        end else begin
            cnt0 <= tick_w[0] ? '0 : cnt0 + 1'b1;
            if (tick_w[0]) cnt1 <= (cnt1 == W1'(DIV1 - 1)) ? '0 : cnt1 + 1'b1;
            if (tick_w[1]) cnt2 <= (cnt2 == W2'(DIV2 - 1)) ? '0 : cnt2 + 1'b1;
            if (tick_w[2]) cnt3 <= (cnt3 == W3'(DIV3 - 1)) ? '0 : cnt3 + 1'b1;
        end
    end

    always_comb begin
        led_next = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            case (bus.mode[2*c +: 2])
                2'b00:   led_next[c] = 1'b0;
                2'b01:   led_next[c] = 1'b1;
                2'b10:   led_next[c] = sq[act_sel[c]];
                default: led_next[c] = ~sq[act_sel[c]];
            endcase
            led_next[c] = led_next[c] & bus.enable;
        end
    end

    // A pending rate request is taken only on the active rate's tick; whatever sel holds then wins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            act_sel <= '0;
            led_q   <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (tick_w[act_sel[c]]) act_sel[c] <= bus.sel[2*c +: 2];
            end
            led_q <= led_next;
        end
    end

    assign bus.tick      = tick_w;
    assign bus.led_drive = led_q;
    assign bus.act_sel   = act_sel;
endmodule

// File: tb/tb_led_blinker_multi.sv
// Self-checking bench for led_blinker_multi: fixed timing table, directed switch/reset runs,
// and random input traffic compared cycle by cycle against an arithmetic model of the rates.
module tb_led_blinker_multi;
    localparam int NUM_CH = 4;

    typedef struct {
        int         edge_n;
        logic       en;
        logic [3:0] exp_led;
        logic [3:0] exp_tick;
    } vec_t;

    logic clock;
    logic reset_n;

    led_blinker_multi_if #(.NUM_CH(NUM_CH)) bus ();

    led_blinker_multi #(
        .NUM_CH(NUM_CH), .DIV0(250), .DIV1(2), .DIV2(5), .DIV3(10)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          total;
    int          bad;
    int unsigned n;
    int unsigned divs [4];
    int unsigned per  [5];
    logic [1:0]  m_act [NUM_CH];
    vec_t        vecs  [12];

    // Rate k has period per[k+1]; its counter advances every per[k] cycles.
    function automatic logic m_sq(input int k, input int unsigned t);
        return ((t % per[k+1]) / per[k]) >= (divs[k] / 2);
    endfunction

    function automatic logic m_tick(input int k, input int unsigned t);
        return (t % per[k+1]) == (per[k+1] - 1);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s edge=%0d got=%0h exp=%0h", name, n, got, exp);
        end
    endtask

    // One clock: predict from the state after edge n and the inputs now applied, then compare.
    task automatic step();
        logic [NUM_CH-1:0] e_led;
        logic [3:0]        e_tick;
        logic [1:0]        nxt [NUM_CH];
        logic              s;
        for (int c = 0; c < NUM_CH; c++) begin
            s = m_sq(int'(m_act[c]), n);
            case (bus.mode[2*c +: 2])
                2'b00:   e_led[c] = 1'b0;
                2'b01:   e_led[c] = 1'b1;
                2'b10:   e_led[c] = s;
                default: e_led[c] = ~s;
            endcase
            e_led[c] = e_led[c] & bus.enable;
            nxt[c] = m_tick(int'(m_act[c]), n) ? bus.sel[2*c +: 2] : m_act[c];
        end
        @(posedge clock);
        n++;
        for (int c = 0; c < NUM_CH; c++) m_act[c] = nxt[c];
        for (int k = 0; k < 4; k++) e_tick[k] = m_tick(k, n);
        #1;
        check("model_led", 32'(bus.led_drive), 32'(e_led));
        check("model_tick", 32'(bus.tick), 32'(e_tick));
    endtask

    task automatic run_reset();
        @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        n = 0;
        for (int c = 0; c < NUM_CH; c++) m_act[c] = 2'd0;
    endtask

    task automatic run_table();
        for (int i = 0; i < 12; i++) begin
            while (n < vecs[i].edge_n) begin
                bus.enable = vecs[i].en;
                step();
            end
            check($sformatf("tbl_led_%0d", vecs[i].edge_n), 32'(bus.led_drive), 32'(vecs[i].exp_led));
            check($sformatf("tbl_tick_%0d", vecs[i].edge_n), 32'(bus.tick), 32'(vecs[i].exp_tick));
        end
    endtask

    initial begin
        logic cur, prev;
        int   run_len, min_run, hi2;

        total = 0;
        bad   = 0;
        n     = 0;
        divs[0] = 250; divs[1] = 2; divs[2] = 5; divs[3] = 10;
        per[0] = 1;
        for (int k = 0; k < 4; k++) per[k+1] = per[k] * divs[k];
        for (int c = 0; c < NUM_CH; c++) m_act[c] = 2'd0;

        // ch0 blink, ch1 on, ch2 off, ch3 inverted blink, all at rate 0.
        vecs[0]  = '{1,   1'b1, 4'b1010, 4'b0000};
        vecs[1]  = '{125, 1'b1, 4'b1010, 4'b0000};
        vecs[2]  = '{126, 1'b1, 4'b0011, 4'b0000};
        vecs[3]  = '{249, 1'b1, 4'b0011, 4'b0001};
        vecs[4]  = '{250, 1'b1, 4'b0011, 4'b0000};
        vecs[5]  = '{251, 1'b1, 4'b1010, 4'b0000};
        vecs[6]  = '{300, 1'b1, 4'b1010, 4'b0000};
        vecs[7]  = '{301, 1'b0, 4'b0000, 4'b0000};
        vecs[8]  = '{400, 1'b0, 4'b0000, 4'b0000};
        vecs[9]  = '{401, 1'b1, 4'b0011, 4'b0000};
        vecs[10] = '{499, 1'b1, 4'b0011, 4'b0011};
        vecs[11] = '{500, 1'b1, 4'b0011, 4'b0000};

        bus.enable = 1'b1;
        bus.sel    = 8'h00;
        bus.mode   = 8'b11_00_01_10;
        reset_n    = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check("reset_led", 32'(bus.led_drive), 32'h0);
        check("reset_tick", 32'(bus.tick), 32'h0);
        check("reset_act", 32'(bus.act_sel), 32'h0);

        run_reset();
        run_table();

        bus.mode[3:2] = 2'b00;
        step();
        check("ch1_off", 32'(bus.led_drive[1]), 32'h0);
        bus.mode[3:2] = 2'b01;
        step();
        check("ch1_on", 32'(bus.led_drive[1]), 32'h1);

        // Rate switch from 1 Hz to 100 Hz requested mid-period; channels 1..3 at rates 1..3.
        bus.enable = 1'b1;
        bus.mode   = 8'b10_10_10_10;
        bus.sel    = {2'd3, 2'd2, 2'd1, 2'd3};
        run_reset();
        prev = 1'b0; run_len = 0; min_run = 1 << 30; hi2 = 0;
        while (n < 25200) begin
            if (n == 1000) bus.sel[1:0] = 2'd0;
            step();
            cur = bus.led_drive[0];
            if (cur == prev) run_len++;
            else begin
                if (run_len < min_run) min_run = run_len;
                run_len = 1;
                prev    = cur;
            end
            if (n >= 2501 && n <= 25000 && bus.led_drive[2]) hi2++;
            case (n)
                12500: check("sw_before_1hz_high", 32'(cur), 32'h0);
                12501: check("sw_1hz_high", 32'(cur), 32'h1);
                25000: check("sw_hold_until_boundary", 32'(cur), 32'h1);
                25001: check("sw_100hz_low", 32'(cur), 32'h0);
                25125: check("sw_100hz_still_low", 32'(cur), 32'h0);
                25126: check("sw_100hz_first_high", 32'(cur), 32'h1);
                default: ;
            endcase
        end
        check("sw_min_pulse_ge_125", 32'(min_run >= 125), 32'h1);
        check("ch2_high_count", 32'(hi2), 32'd13500);

        // Asynchronous reset half a cycle after edge 12345, then the fixed table again.
        bus.sel  = 8'h00;
        bus.mode = 8'b11_00_01_10;
        run_reset();
        while (n < 12345) step();
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("midreset_led", 32'(bus.led_drive), 32'h0);
        check("midreset_tick", 32'(bus.tick), 32'h0);
        run_reset();
        run_table();

        // Random sel/mode/enable traffic across more than one full 1 Hz period.
        run_reset();
        for (int i = 0; i < 26000; i++) begin
            if ($urandom_range(0, 49) == 0) bus.sel = 8'($urandom);
            if ($urandom_range(0, 99) == 0) bus.mode = 8'($urandom);
            if ($urandom_range(0, 199) == 0) bus.enable = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
